// File: rtl/piso_using_generate.sv
// Parallel-in serial-out shifter: a WIDTH-bit word is accepted on a valid/ready
// handshake and sent one bit per clock. Optional parity bit: define PISO_PARITY_EN.
module piso_using_generate #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME_W = WIDTH + 1;
`else
  localparam int unsigned FRAME_W = WIDTH;
`endif
  localparam int unsigned        CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(FRAME_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] frame_load;
  logic [FRAME_W-1:0] frame_next;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               last_bit;
  logic               accept;

  // The output end of the shift register and the shift direction depend on bit order;
  // the parity bit always sits at the far end so it leaves after the data bits.
  generate
    if (MSB_FIRST) begin : g_msb_first
`ifdef PISO_PARITY_EN
      assign frame_load = {din, ^din};
`else
      assign frame_load = din;
`endif
      assign frame_next = {shift_q[FRAME_W-2:0], 1'b0};
      assign dout       = shift_q[FRAME_W-1];
    end else begin : g_lsb_first
`ifdef PISO_PARITY_EN
      assign frame_load = {^din, din};
`else
      assign frame_load = din;
`endif
      assign frame_next = {1'b0, shift_q[FRAME_W-1:1]};
      assign dout       = shift_q[0];
    end
  endgenerate

  assign last_bit   = (state_q == SHIFT) && (count_q == LAST_CNT);
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;
  assign dout_valid = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT);
  assign dout_last  = last_bit;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    if (accept) begin
      state_d = SHIFT;
      shift_d = frame_load;
      count_d = '0;
    end else if (last_bit) begin
      // Clearing the register on the way to IDLE keeps dout low while idle.
      state_d = IDLE;
      shift_d = '0;
      count_d = '0;
    end else if (state_q == SHIFT) begin
      shift_d = frame_next;
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

endmodule
